// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame parser: FSM state encoding, frame
// header bytes and error-cause codes reported on err_code.
// Optional feature macro used by the parser: UART_FRAME_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR2 = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_SEND = 3'd5
  } state_e;

  localparam logic [7:0] HDR_BYTE1 = 8'hAA;
  localparam logic [7:0] HDR_BYTE2 = 8'h55;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage : uart_pkg

// File: rtl/uart_frame_buf.sv
// -----------------------------------------------------------------------------
// uart_frame_buf
// Payload storage for one frame: DEPTH x 8 bits, one synchronous write port
// and one asynchronous (combinational) read port.
// Ports:
//   clk        system clock
//   we_i       write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  read address
//   rd_data_o  read data, combinational from rd_addr_i
// -----------------------------------------------------------------------------
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; every entry is written before it is
  // read within a frame, and resetting it would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_frame_buf

// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
// Parses frames "AA 55 LEN payload[LEN] CHK" from a byte-strobe UART receiver,
// where CHK = (LEN + sum of payload) mod 256. A frame that passes its checksum
// is replayed to the consumer over a valid/ready interface; failures and
// overruns are reported as one-cycle err_flag pulses with a cause in err_code.
//
// Optional feature: define UART_FRAME_TIMEOUT_EN to abandon a partial frame
// after (CLK_FREQ/UART_BPS)*30 cycles without a byte (err_code 0).
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   pi_data    received byte, valid while pi_flag is high
//   pi_flag    one-cycle byte strobe
//   out_data   payload byte to the consumer (0 outside SEND)
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data when out_valid is high
//   out_last   out_data is the final payload byte
//   frame_ok   one-cycle pulse on a good checksum
//   err_flag   one-cycle error pulse
//   err_code   error cause, valid with err_flag
// -----------------------------------------------------------------------------
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200,
  parameter int MAX_LEN  = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       err_flag,
  output logic [1:0] err_code
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic       frame_ok_q, frame_ok_d;
  logic       err_flag_q, err_flag_d;
  logic [1:0] err_code_q, err_code_d;

  logic       len_bad;
  logic       last_wr;
  logic       last_rd;
  logic       sum_match;
  logic       accept;
  logic       buf_we;
  logic [7:0] buf_rd_data;
  logic       timeout;

  assign len_bad   = (pi_data == 8'd0) || (pi_data > 8'(MAX_LEN));
  assign last_wr   = (wr_ptr_q == len_q - 8'd1);
  assign last_rd   = (rd_ptr_q == len_q - 8'd1);
  assign sum_match = (pi_data == sum_q);
  assign accept    = (state_q == ST_SEND) && out_ready;
  assign buf_we    = (state_q == ST_DATA) && pi_flag;

  // ---------------------------------------------------------------------------
  // Inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TIMEOUT_RAW = (CLK_FREQ / UART_BPS) * 30;
  localparam int unsigned TIMEOUT_CYC = (TIMEOUT_RAW == 0) ? 1 : TIMEOUT_RAW;
  localparam int          TW          = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          timer_active;

  assign timer_active = (state_q == ST_HDR2) || (state_q == ST_LEN) ||
                        (state_q == ST_DATA) || (state_q == ST_CHK);

  // A byte arriving on the expiry cycle wins: it reloads the timer instead.
  assign timeout = timer_active && !pi_flag &&
                   (timer_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (!timer_active || pi_flag) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default at the top of the
  // block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pi_flag && pi_data == HDR_BYTE1) state_d = ST_HDR2;
      ST_HDR2: begin
        if (pi_flag) begin
          if (pi_data == HDR_BYTE2)      state_d = ST_LEN;
          else if (pi_data == HDR_BYTE1) state_d = ST_HDR2;
          else                           state_d = ST_IDLE;
        end
      end
      ST_LEN:  if (pi_flag) state_d = len_bad ? ST_IDLE : ST_DATA;
      ST_DATA: if (pi_flag && last_wr) state_d = ST_CHK;
      ST_CHK:  if (pi_flag) state_d = sum_match ? ST_SEND : ST_IDLE;
      ST_SEND: if (accept && last_rd) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (consumer side is Moore on state; pulses are registered)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid  = (state_q == ST_SEND);
    out_last   = out_valid && last_rd;
    out_data   = out_valid ? buf_rd_data : 8'd0;
    frame_ok_d = (state_q == ST_CHK) && pi_flag && sum_match;
    err_flag_d = 1'b0;
    err_code_d = 2'd0;
    if (timeout) begin
      err_flag_d = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else if (pi_flag) begin
      unique case (state_q)
        ST_LEN: if (len_bad) begin
          err_flag_d = 1'b1;
          err_code_d = ERR_LEN;
        end
        ST_CHK: if (!sum_match) begin
          err_flag_d = 1'b1;
          err_code_d = ERR_CHK;
        end
        // The byte is dropped; SEND and rd_ptr carry on untouched.
        ST_SEND: begin
          err_flag_d = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        default: ;
      endcase
    end
  end

  assign frame_ok = frame_ok_q;
  assign err_flag = err_flag_q;
  assign err_code = err_code_q;

  // ---------------------------------------------------------------------------
  // Datapath: length, running checksum, buffer pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    len_d    = len_q;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pi_flag) begin
      unique case (state_q)
        ST_LEN: if (!len_bad) begin
          len_d    = pi_data;
          sum_d    = pi_data;
          wr_ptr_d = 8'd0;
        end
        ST_DATA: begin
          sum_d    = sum_q + pi_data;
          wr_ptr_d = wr_ptr_q + 8'd1;
        end
        ST_CHK:  rd_ptr_d = 8'd0;
        default: ;
      endcase
    end
    if (accept && !last_rd) begin
      rd_ptr_d = rd_ptr_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      len_q      <= 8'd0;
      sum_q      <= 8'd0;
      wr_ptr_q   <= 8'd0;
      rd_ptr_q   <= 8'd0;
      frame_ok_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      len_q      <= len_d;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      frame_ok_q <= frame_ok_d;
      err_flag_q <= err_flag_d;
      err_code_q <= err_code_d;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk       (sys_clk),
    .we_i      (buf_we),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (pi_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (buf_rd_data)
  );

endmodule : uart_frame_parser

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
// Directed bench for uart_frame_parser with hand-computed frames and checksums.
// Timeout scenarios run only when UART_FRAME_TIMEOUT_EN is defined; with
// CLK_FREQ=1_000_000 and UART_BPS=100_000 the timeout is 300 cycles.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       err_flag;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state, written only by the monitor process (queues are cleared by
  // the stimulus before each scenario).
  int         ok_cnt    = 0;
  int         ok_nv_cnt = 0;
  int         err_cnt   = 0;
  int         valid_cyc = 0;
  logic [1:0] last_code = 2'd0;
  logic [7:0] beat_data [$];
  logic       beat_last [$];
  logic [7:0] exp_data  [$];

  uart_frame_parser #(
    .CLK_FREQ (1_000_000),
    .UART_BPS (100_000),
    .MAX_LEN  (16)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pi_data   (pi_data),
    .pi_flag   (pi_flag),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .err_flag  (err_flag),
    .err_code  (err_code)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (frame_ok) begin
        ok_cnt++;
        if (!out_valid) ok_nv_cnt++;
      end
      if (err_flag) begin
        err_cnt++;
        last_code = err_code;
      end
      if (out_valid) valid_cyc++;
      if (out_valid && out_ready) begin
        beat_data.push_back(out_data);
        beat_last.push_back(out_last);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk);
    #1;
    pi_data = b;
    pi_flag = 1'b1;
    @(posedge sys_clk);
    #1;
    pi_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_beats();
    beat_data.delete();
    beat_last.delete();
    exp_data.delete();
  endtask

  // Compares captured beats against exp_data; out_last expected on the final.
  task automatic check_beats(input string tag);
    int n;
    check({tag, " beats"}, beat_data.size(), exp_data.size());
    n = (beat_data.size() < exp_data.size()) ? beat_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s data[%0d]", tag, i), beat_data[i], exp_data[i]);
      check($sformatf("%s last[%0d]", tag, i), beat_last[i], (i == exp_data.size() - 1));
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    idle(3);
    sys_rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ok0, err0, val0;
    logic [7:0] s;
    bit got;

    pi_data   = 8'd0;
    pi_flag   = 1'b0;
    out_ready = 1'b1;
    sys_rst_n = 1'b0;
    idle(2);
    @(negedge sys_clk);
    check("rst out_data",  out_data,  0);
    check("rst out_valid", out_valid, 0);
    check("rst out_last",  out_last,  0);
    check("rst frame_ok",  frame_ok,  0);
    check("rst err_flag",  err_flag,  0);
    check("rst err_code",  err_code,  0);
    sys_rst_n = 1'b1;
    idle(2);

    // Good frame, consumer always ready.
    clear_beats();
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    @(negedge sys_clk);
    check("good frame_ok latency", frame_ok, 1);
    check("good out_valid with ok", out_valid, 1);
    check("good first out_data", out_data, 8'h11);
    idle(6);
    exp_data.push_back(8'h11); exp_data.push_back(8'h22); exp_data.push_back(8'h33);
    check_beats("good");
    check("good frame_ok count", ok_cnt - ok0, 1);
    check("good err count", err_cnt - err0, 0);
    check("good ok without valid", ok_nv_cnt, 0);
    check("good back to idle", out_valid, 0);

    // Bad checksum.
    clear_beats();
    ok0 = ok_cnt; err0 = err_cnt; val0 = valid_cyc;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h68);
    idle(4);
    check("badchk err count", err_cnt - err0, 1);
    check("badchk err code", last_code, 2);
    check("badchk no frame_ok", ok_cnt - ok0, 0);
    check("badchk no out_valid", valid_cyc - val0, 0);

    // Length zero and length above MAX_LEN.
    err0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
    idle(3);
    check("len0 err count", err_cnt - err0, 1);
    check("len0 err code", last_code, 1);
    err0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h11);
    idle(3);
    check("len17 err count", err_cnt - err0, 1);
    check("len17 err code", last_code, 1);

    // Length exactly MAX_LEN: payload 01..10, CHK = 0x10 + 0x88 = 0x98.
    clear_beats();
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) begin
      send_byte(8'(i));
      exp_data.push_back(8'(i));
    end
    send_byte(8'h98);
    idle(20);
    check_beats("len16");
    check("len16 frame_ok count", ok_cnt - ok0, 1);
    check("len16 err count", err_cnt - err0, 0);

    // Overrun with consumer stalled: A1 B2, CHK = 02 + A1 + B2 = 0x55.
    clear_beats();
    out_ready = 1'b0;
    err0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'h55);
    idle(2);
    send_byte(8'h44);
    idle(2);
    @(negedge sys_clk);
    check("ovr err count", err_cnt - err0, 1);
    check("ovr err code", last_code, 3);
    check("ovr still valid", out_valid, 1);
    check("ovr out_data held", out_data, 8'hA1);
    check("ovr not last", out_last, 0);
    // Overrun byte coinciding with the first handshake.
    err0 = err_cnt;
    @(posedge sys_clk);
    #1;
    out_ready = 1'b1;
    pi_data   = 8'h44;
    pi_flag   = 1'b1;
    @(posedge sys_clk);
    #1;
    pi_flag = 1'b0;
    idle(4);
    exp_data.push_back(8'hA1); exp_data.push_back(8'hB2);
    check_beats("ovr");
    check("ovr+hs err count", err_cnt - err0, 1);
    check("ovr+hs err code", last_code, 3);
    check("ovr idle after", out_valid, 0);

    // Reset while in SEND abandons the frame.
    out_ready = 1'b0;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01);
    send_byte(8'h7F); send_byte(8'h80);
    @(negedge sys_clk);
    check("pre-reset in send", out_valid, 1);
    do_reset();
    @(negedge sys_clk);
    check("post-reset out_valid", out_valid, 0);
    check("post-reset out_data", out_data, 0);
    out_ready = 1'b1;

    // Resynchronisation on a repeated header byte.
    clear_beats();
    ok0 = ok_cnt;
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    idle(4);
    exp_data.push_back(8'h7F);
    check_beats("resync");
    check("resync frame_ok count", ok_cnt - ok0, 1);

`ifdef UART_FRAME_TIMEOUT_EN
    // Partial frame then silence: err_code 0 near 300 cycles after last byte.
    err0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02); send_byte(8'h01);
    idle(250);
    check("tmo not early", err_cnt - err0, 0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge sys_clk);
      if (err_cnt != err0) got = 1'b1;
    end
    check("tmo fired", got, 1);
    check("tmo err code", last_code, 0);
    idle(2);
    clear_beats();
    ok0 = ok_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01);
    send_byte(8'h7F); send_byte(8'h80);
    idle(4);
    exp_data.push_back(8'h7F);
    check_beats("post-tmo");
    check("post-tmo frame_ok", ok_cnt - ok0, 1);
`endif

    s = 8'd0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_uart_frame_parser

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, line baud rate used for the timeout length.
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-004 SHALL have port sys_clk  input  1  single system clock, all logic on the rising edge.
REQ-005 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pi_data  input  8  received byte from the upstream UART receiver.
REQ-007 SHALL have port pi_flag  input  1  one-cycle strobe; pi_data is valid while it is high.
REQ-008 SHALL have port out_data  output  8  payload byte to the consumer.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.
REQ-011 SHALL have port out_last  output  1  out_data is the final payload byte of the frame.
REQ-012 SHALL have port frame_ok  output  1  one-cycle pulse when a frame passes its checksum.
REQ-013 SHALL have port err_flag  output  1  one-cycle error pulse.
REQ-014 SHALL have port err_code  output  2  error cause, valid with err_flag: 0 timeout, 1 bad length, 2 bad checksum, 3 overrun.

Function
REQ-015 SHALL accept frames of the form 0xAA, 0x55, LEN, LEN payload bytes, CHK, where CHK is (LEN + sum of payload) mod 256.
REQ-016 SHALL implement states IDLE, HDR2, LEN, DATA, CHK and SEND, and advance only on a pi_flag cycle, except in SEND and on timeout.
REQ-017 SHALL move IDLE->HDR2 on byte 0xAA; any other byte leaves it in IDLE with no error.
REQ-018 SHALL move HDR2->LEN on 0x55, stay in HDR2 on 0xAA, and go HDR2->IDLE on any other byte, with no error.
REQ-019 SHALL, in LEN, treat LEN=0 or LEN>MAX_LEN as an error: pulse err_flag with code 1 and go to IDLE; otherwise latch LEN, set the running sum to LEN and go to DATA.
REQ-020 SHALL, in DATA, write each byte to buffer[wr_ptr], add it to the 8-bit running sum with wrap-around, and go to CHK after byte LEN-1.
REQ-021 SHALL, in CHK, pulse frame_ok, reset rd_ptr to 0 and go to SEND if the byte equals the sum; otherwise pulse err_flag with code 2 and go to IDLE.
REQ-022 SHALL assert out_valid in SEND, starting in the same cycle as frame_ok, which is one cycle after the CHK pi_flag.
REQ-023 SHALL hold out_data = buffer[rd_ptr] stable until accepted, and advance rd_ptr on each out_valid&&out_ready.
REQ-024 SHALL assert out_last only while rd_ptr==LEN-1; acceptance of that byte returns the parser to IDLE with out_valid low on the next cycle.
REQ-025 SHALL drop a pi_flag byte arriving in SEND and pulse err_flag with code 3, including when it coincides with a handshake; SEND and rd_ptr are unaffected.
REQ-026 SHALL never produce out_valid for a frame that failed its checksum, and payload order SHALL equal arrival order.

Reset
REQ-027 SHALL, on reset, go to IDLE, clear the pointers, sum and timer, and drive out_data=0, out_valid=0, out_last=0, frame_ok=0, err_flag=0 and err_code=0.
REQ-028 SHALL abandon a frame in progress when reset occurs mid-frame, including in SEND; buffer contents need not be cleared.

Configuration
REQ-029 SHALL, with macro UART_FRAME_TIMEOUT_EN defined, count cycles since the last pi_flag while in HDR2, LEN, DATA or CHK.
REQ-030 SHALL, with that macro defined, go to IDLE and pulse err_flag with code 0 after (CLK_FREQ/UART_BPS)*30 cycles.
REQ-031 SHALL, with that macro defined, reload the counter on every pi_flag.
REQ-032 SHALL, without that macro, contain no timer and never produce err_code 0 with err_flag.

Structure
REQ-033 SHALL take the state encodings, header constants 0xAA and 0x55, and error code constants from the shared package uart_pkg.
REQ-034 SHALL place the MAX_LEN x 8 payload storage in sub-module uart_frame_buf, with one write port and one asynchronous read port.

Verification
REQ-035 SHALL verify that AA 55 03 11 22 33 69 with out_ready=1 yields frame_ok once, then 11, 22, 33, with out_last only on 33.
REQ-036 SHALL verify that AA 55 03 11 22 33 68 yields err_flag with code 2 and no out_valid.
REQ-037 SHALL verify that AA 55 00 yields err_flag with code 1, and that AA 55 11 with MAX_LEN=16 also yields code 1.
REQ-038 SHALL verify that AA AA 55 01 7F 80 resynchronises and outputs 7F with out_last.
REQ-039 SHALL verify that, with out_ready held at 0 in SEND, a byte 0x44 yields err_code 3 and out_data holds its first byte.
REQ-040 SHALL verify, with UART_FRAME_TIMEOUT_EN defined, that AA 55 02 01 followed by silence yields err_code 0 after the timeout, and that AA 55 01 7F 80 then parses.
